// File: rtl/sid_filter_mixer_if.sv
// Sample-path bundle between the filter, the mixer and the DAC/PWM stage.
// The filter side drives the inputs (master); the mixer consumes them (slave).
interface sid_filter_mixer_if;
    logic              sample_valid;
    logic signed [7:0] filt_hp;
    logic signed [7:0] filt_bp;
    logic signed [7:0] filt_lp;
    logic signed [7:0] bypass_in;
    logic        [2:0] mode;
    logic        [3:0] volume;
    logic signed [7:0] audio_out;
    logic              out_valid;
    logic              busy;
    logic              overrun;

    modport master (
        output sample_valid, filt_hp, filt_bp, filt_lp, bypass_in, mode, volume,
        input  audio_out, out_valid, busy, overrun
    );

    modport slave (
        input  sample_valid, filt_hp, filt_bp, filt_lp, bypass_in, mode, volume,
        output audio_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/sid_filter_mixer.sv
// SID output mixer: mode-selected filter taps plus bypass, scaled by volume/16
// through a 4-step shift-add multiplier, then saturated to 8-bit signed.
//
//   state  | meaning
//   IDLE   | waiting for sample_valid; captures inputs on strobe
//   SUM    | adds enabled filter taps and bypass, clears accumulator
//   MUL    | one shift-add per volume bit, MSB first (4 cycles)
//   OUT    | floors acc/16, saturates, pulses out_valid
module sid_filter_mixer (
    input  logic                 clk,
    input  logic                 rst_n,
    sid_filter_mixer_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUM  = 2'd1,
        S_MUL  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic signed [7:0]  r_hp;
    logic signed [7:0]  r_bp;
    logic signed [7:0]  r_lp;
    logic signed [7:0]  r_byp;
    logic        [2:0]  r_mode;
    logic        [3:0]  r_vol;
    logic signed [9:0]  r_sum;
    logic signed [13:0] r_acc;
    logic        [1:0]  r_cnt;
    logic signed [7:0]  r_audio;
    logic               r_out_valid;
    logic               r_overrun;

    logic               w_capture;
    logic               w_drop;
    logic               w_sum_ld;
    logic               w_mul_step;
    logic               w_out_ld;
    logic               w_busy;

    logic signed [9:0]  w_hp_term;
    logic signed [9:0]  w_bp_term;
    logic signed [9:0]  w_lp_term;
    logic signed [9:0]  w_sum;
    logic signed [13:0] w_addend;
    logic signed [13:0] w_acc_next;
    logic signed [13:0] w_shr;
    logic signed [7:0]  w_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (bus.sample_valid) w_next_state = S_SUM;
            S_SUM:  w_next_state = S_MUL;
            S_MUL:  if (r_cnt == 2'd0) w_next_state = S_OUT;
            S_OUT:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state != S_IDLE);
        w_capture  = (r_state == S_IDLE) && bus.sample_valid;
        w_drop     = (r_state != S_IDLE) && bus.sample_valid;
        w_sum_ld   = (r_state == S_SUM);
        w_mul_step = (r_state == S_MUL);
        w_out_ld   = (r_state == S_OUT);
    end

    // 10-bit sum of four 8-bit signed terms cannot overflow (-512..508).
    always_comb begin
        w_hp_term = r_mode[2] ? {{2{r_hp[7]}}, r_hp} : 10'sd0;
        w_bp_term = r_mode[1] ? {{2{r_bp[7]}}, r_bp} : 10'sd0;
        w_lp_term = r_mode[0] ? {{2{r_lp[7]}}, r_lp} : 10'sd0;
        w_sum     = w_hp_term + w_bp_term + w_lp_term + {{2{r_byp[7]}}, r_byp};
    end

    always_comb begin
        w_addend   = r_vol[r_cnt] ? {{4{r_sum[9]}}, r_sum} : 14'sd0;
        w_acc_next = (r_acc <<< 1) + w_addend;
    end

    always_comb begin
        w_shr = r_acc >>> 4;
        if (w_shr > 14'sd127)
            w_sat = 8'sd127;
        else if (w_shr < -14'sd128)
            w_sat = -8'sd128;
        else
            w_sat = w_shr[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hp   <= '0;
            r_bp   <= '0;
            r_lp   <= '0;
            r_byp  <= '0;
            r_mode <= '0;
            r_vol  <= '0;
        end else if (w_capture) begin
            r_hp   <= bus.filt_hp;
            r_bp   <= bus.filt_bp;
            r_lp   <= bus.filt_lp;
            r_byp  <= bus.bypass_in;
            r_mode <= bus.mode;
            r_vol  <= bus.volume;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_sum_ld) begin
            r_sum <= w_sum;
            r_acc <= '0;
            r_cnt <= 2'd3;
        end else if (w_mul_step) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_audio     <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= w_out_ld;
            r_overrun   <= w_drop;
            if (w_out_ld) r_audio <= w_sat;
        end
    end

    assign bus.audio_out = r_audio;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = w_busy;
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_sid_filter_mixer.sv
// Directed bench for sid_filter_mixer: hand-computed vectors for mixing,
// volume scaling, saturation, floor rounding, overrun and mid-sample reset.
module tb_sid_filter_mixer;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    sid_filter_mixer_if bus ();

    sid_filter_mixer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [15:0] obs,
                       input logic signed [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Strobe one sample, then check the 6-edge latency and the result.
    task automatic run_sample(input string tag,
                              input logic signed [7:0] hp, input logic signed [7:0] bp,
                              input logic signed [7:0] lp, input logic signed [7:0] byp,
                              input logic [2:0] md, input logic [3:0] vol,
                              input logic [3:0] vol_after,
                              input logic signed [7:0] expected);
        @(negedge clk);
        bus.filt_hp      = hp;
        bus.filt_bp      = bp;
        bus.filt_lp      = lp;
        bus.bypass_in    = byp;
        bus.mode         = md;
        bus.volume       = vol;
        bus.sample_valid = 1'b1;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        bus.volume       = vol_after;
        bus.filt_lp      = ~lp;
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_no_ovr"}, bus.overrun, 0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            chk({tag, "_early_valid"}, bus.out_valid, 0);
        end
        @(posedge clk); #1;
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_audio"}, $signed(bus.audio_out), expected);
        chk({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        int n_valid;
        int n_ovr;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.sample_valid = 1'b0;
        bus.filt_hp = '0;
        bus.filt_bp = '0;
        bus.filt_lp = '0;
        bus.bypass_in = '0;
        bus.mode = '0;
        bus.volume = '0;
        #1;
        chk("rst_audio", $signed(bus.audio_out), 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ovr", bus.overrun, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // lp=64, vol=15 -> 960/16 = 60; valid drops the cycle after
        run_sample("lp_vol15", 0, 0, 64, 0, 3'b001, 4'd15, 4'd15, 60);
        @(posedge clk); #1;
        chk("valid_one_cycle", bus.out_valid, 0);
        chk("audio_hold", $signed(bus.audio_out), 60);

        // reset asserted while in MUL
        @(negedge clk);
        bus.filt_lp = 8'sd100; bus.mode = 3'b001; bus.volume = 4'd15;
        bus.sample_valid = 1'b1;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_audio", $signed(bus.audio_out), 0);
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_ovr", bus.overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_valid = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) n_valid++;
        end
        chk("midrst_no_valid", n_valid, 0);
        run_sample("after_rst", 0, 0, 64, 0, 3'b001, 4'd15, 4'd15, 60);

        // saturation: 508*15=7620 -> 476 -> 127; -512*15=-7680 -> -480 -> -128
        run_sample("sat_pos", 127, 127, 127, 127, 3'b111, 4'd15, 4'd15, 127);
        run_sample("sat_neg", -128, -128, -128, -128, 3'b111, 4'd15, 4'd15, -128);

        // bypass only; volume changed after capture must not matter
        run_sample("vol8", 50, 50, 50, -100, 3'b000, 4'd8, 4'd0, -50);
        run_sample("vol0", 50, 50, 50, -100, 3'b000, 4'd0, 4'd15, 0);

        // floor: -3/16 -> -1, 3/16 -> 0
        run_sample("floor_neg", 0, -3, 0, 0, 3'b010, 4'd1, 4'd1, -1);
        run_sample("floor_pos", 0, 3, 0, 0, 3'b010, 4'd1, 4'd1, 0);

        // hp+bp mix: (20+10+5)*5 = 175 -> 10
        run_sample("hp_bp_mix", 20, 10, 99, 5, 3'b110, 4'd5, 4'd5, 10);

        // overrun: second strobe 3 cycles after accept
        @(negedge clk);
        bus.filt_hp = 0; bus.filt_bp = 0; bus.bypass_in = 0;
        bus.filt_lp = 8'sd64; bus.mode = 3'b001; bus.volume = 4'd15;
        bus.sample_valid = 1'b1;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.filt_lp = -8'sd64;
        bus.sample_valid = 1'b1;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        chk("ovr_pulse", bus.overrun, 1);
        n_valid = 0;
        n_ovr = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.overrun === 1'b1) n_ovr++;
            if (bus.out_valid === 1'b1) begin
                n_valid++;
                chk("ovr_first_result", $signed(bus.audio_out), 60);
            end
        end
        chk("ovr_single_pulse", n_ovr, 0);
        chk("ovr_one_valid", n_valid, 1);

        // back-to-back at exactly 7-cycle spacing
        run_sample("b2b_0", 0, 0, 32, 0, 3'b001, 4'd15, 4'd15, 30);
        run_sample("b2b_1", 0, 0, -32, 0, 3'b001, 4'd15, 4'd15, -30);
        run_sample("b2b_2", 0, 0, 0, 16, 3'b000, 4'd15, 4'd15, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
